ram_param: RTL and testbench

- Parametrised single-port RAM that succeeds the fixed 16-bit x 4K RAM.
- Adds configurable word width and depth, a selectable combinational or registered read path, and a hardware clear sequencer.
- The clear sequencer zeroes every word after reset or on request.
- Sits on the CPU data-memory path; busy tells the CPU or memory controller when the RAM is not accepting writes.

---
 rtl/ram_param.sv | 93 +++++++++
 tb/tb_ram_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_param.sv
// Parametrised single-port RAM with a hardware clear sequencer.
// Ports: clk, reset (async, high), load/address/in (write), clear (zero sweep
// request), out (read data), busy (sweep running), clear_done (last sweep write).
module ram_param #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 12,
    parameter int SYNC_READ = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [ADDR_BITS-1:0] address,
    input  logic [WIDTH-1:0]     in,
    input  logic                 clear,
    output logic [WIDTH-1:0]     out,
    output logic                 busy,
    output logic                 clear_done
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [ADDR_BITS-1:0]   clr_ptr;
    logic                   clr_last;
    logic [WIDTH-1:0]       mem [DEPTH];

    // Terminal compare on the pointer before it wraps back to zero.
    assign clr_last = (clr_ptr == ADDR_BITS'(DEPTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            // Wraps to zero on the final sweep write, so IDLE always holds 0.
            if (state == S_CLEAR)
                clr_ptr <= clr_ptr + 1'b1;
            else
                clr_ptr <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_CLEAR: if (clr_last) state_nxt = S_IDLE;
            S_IDLE:  if (clear)    state_nxt = S_CLEAR;
            default: state_nxt = S_CLEAR;
        endcase
    end

    assign busy       = (state == S_CLEAR);
    assign clear_done = busy & clr_last & ~reset;

    // Array is never reset; the sweep zeroes it. User writes are
    // blocked while sweeping.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR)
            mem[clr_ptr] <= '0;
        else if (load)
            mem[address] <= in;
    end

    generate
        if (SYNC_READ != 0) begin : g_sync
            logic [WIDTH-1:0] out_q;

            // Write-first: a write on this edge is what the port returns.
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    out_q <= '0;
                else if (state == S_CLEAR || clear)
                    out_q <= '0;
                else if (load)
                    out_q <= in;
                else
                    out_q <= mem[address];
            end

            assign out = out_q;
        end else begin : g_comb
            assign out = (state == S_CLEAR) ? '0 : mem[address];
        end
    endgenerate

endmodule

// File: tb/tb_ram_param.sv
// Self-checking bench for ram_param: directed plan steps plus random
// traffic against a behavioural array model, over three parameter sets.
module tb_ram_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // u0: ADDR_BITS=4, WIDTH=8, comb read
    logic       r0, ld0, cl0;
    logic [3:0] a0;
    logic [7:0] d0, q0;
    logic       b0, cd0;

    // u1: default params, comb read
    logic        r1, ld1, cl1;
    logic [11:0] a1;
    logic [15:0] d1, q1;
    logic        b1, cd1;

    // u2: ADDR_BITS=4, WIDTH=16, registered read
    logic        r2, ld2, cl2;
    logic [3:0]  a2;
    logic [15:0] d2, q2;
    logic        b2, cd2;

    ram_param #(.WIDTH(8), .ADDR_BITS(4), .SYNC_READ(0)) u0 (
        .clk(clk), .reset(r0), .load(ld0), .address(a0), .in(d0),
        .clear(cl0), .out(q0), .busy(b0), .clear_done(cd0)
    );

    ram_param #(.WIDTH(16), .ADDR_BITS(12), .SYNC_READ(0)) u1 (
        .clk(clk), .reset(r1), .load(ld1), .address(a1), .in(d1),
        .clear(cl1), .out(q1), .busy(b1), .clear_done(cd1)
    );

    ram_param #(.WIDTH(16), .ADDR_BITS(4), .SYNC_READ(1)) u2 (
        .clk(clk), .reset(r2), .load(ld2), .address(a2), .in(d2),
        .clear(cl2), .out(q2), .busy(b2), .clear_done(cd2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [7:0]  m0 [16];
    logic [15:0] m2 [16];
    logic [15:0] w_addr [3];
    logic [15:0] w_data [3];

    initial begin
        int done_cnt;
        int cyc;
        int left;
        logic       rl, rc;
        logic [3:0] ra;
        logic [15:0] rd;
        logic [15:0] exp2;

        r0 = 1; ld0 = 0; cl0 = 0; a0 = 0; d0 = 0;
        r1 = 1; ld1 = 0; cl1 = 0; a1 = 0; d1 = 0;
        r2 = 1; ld2 = 0; cl2 = 0; a2 = 0; d2 = 0;
        tick();
        tick();

        // Reset state
        chk("rst_busy", 32'(b0), 32'd1);
        chk("rst_done", 32'(cd0), 32'd0);
        chk("rst_out0", 32'(q0), 32'd0);
        chk("rst_out2", 32'(q2), 32'd0);
        chk("rst_done2", 32'(cd2), 32'd0);

        // Sweep after reset: 16 cycles busy, done on the 16th only
        r0 = 0; r1 = 0; r2 = 0;
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("sw_busy%0d", k), 32'(b0), 32'd1);
            chk($sformatf("sw_done%0d", k), 32'(cd0), 32'(k == 16));
            chk($sformatf("sw_out%0d", k), 32'(q0), 32'd0);
            tick();
        end
        chk("sw_busy_end", 32'(b0), 32'd0);
        chk("sw_done_end", 32'(cd0), 32'd0);
        chk("sw_busy2_end", 32'(b2), 32'd0);
        for (int i = 0; i < 16; i++) begin
            a0 = 4'(i);
            #1;
            chk($sformatf("sw_rd%0d", i), 32'(q0), 32'd0);
        end

        // Registered read, write-first
        ld2 = 1; a2 = 4'h3; d2 = 16'h1234;
        tick();
        chk("sr_wfirst", 32'(q2), 32'h1234);
        ld2 = 0; a2 = 4'h3;
        tick();
        chk("sr_rd3", 32'(q2), 32'h1234);
        a2 = 4'h5;
        chk("sr_lat", 32'(q2), 32'h1234);
        tick();
        chk("sr_rd5", 32'(q2), 32'h0000);

        // Clear request: sweep, out 0, writes ignored
        ld0 = 1; a0 = 4'h7; d0 = 8'h5A;
        tick();
        ld0 = 0;
        chk("cl_pre7", 32'(q0), 32'h5A);
        cl0 = 1;
        tick();
        cl0 = 0;
        ld0 = 1; a0 = 4'h2; d0 = 8'hFF;
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("cl_busy%0d", k), 32'(b0), 32'd1);
            chk($sformatf("cl_out%0d", k), 32'(q0), 32'd0);
            chk($sformatf("cl_done%0d", k), 32'(cd0), 32'(k == 16));
            tick();
        end
        ld0 = 0;
        chk("cl_busy_end", 32'(b0), 32'd0);
        a0 = 4'h7;
        #1;
        chk("cl_rd7", 32'(q0), 32'h00);
        a0 = 4'h2;
        #1;
        chk("cl_rd2", 32'(q0), 32'h00);

        // Reset at sweep cycle 9 restarts a full sweep
        cl0 = 1;
        tick();
        cl0 = 0;
        for (int k = 1; k < 9; k++) tick();
        r0 = 1;
        #1;
        chk("mr_busy", 32'(b0), 32'd1);
        chk("mr_done", 32'(cd0), 32'd0);
        tick();
        tick();
        r0 = 0;
        done_cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("mr_busy%0d", k), 32'(b0), 32'd1);
            if (cd0) done_cnt++;
            tick();
        end
        chk("mr_busy_end", 32'(b0), 32'd0);
        chk("mr_done_cnt", 32'(done_cnt), 32'd1);

        // Simultaneous load and clear: word ends up zero
        ld0 = 1; cl0 = 1; a0 = 4'hA; d0 = 8'h77;
        tick();
        ld0 = 0; cl0 = 0;
        chk("lc_busy", 32'(b0), 32'd1);
        for (int k = 1; k <= 16; k++) tick();
        chk("lc_busy_end", 32'(b0), 32'd0);
        #1;
        chk("lc_rdA", 32'(q0), 32'h00);

        // Default-size instance: bounded wait for its 4096-cycle sweep
        cyc = 0;
        while (b1 && cyc < 5000) begin
            tick();
            cyc++;
        end
        chk("big_sweep_done", 32'(b1), 32'd0);
        w_addr[0] = 16'h001; w_data[0] = 16'h00FF;
        w_addr[1] = 16'h008; w_data[1] = 16'hF0F0;
        w_addr[2] = 16'h100; w_data[2] = 16'hAAAA;
        for (int i = 0; i < 3; i++) begin
            ld1 = 1; a1 = w_addr[i][11:0]; d1 = w_data[i];
            tick();
            ld1 = 0;
            chk($sformatf("big_wr%0d", i), 32'(q1), 32'(w_data[i]));
        end
        for (int i = 0; i < 3; i++) begin
            a1 = w_addr[i][11:0];
            #1;
            chk($sformatf("big_rd%0d", i), 32'(q1), 32'(w_data[i]));
        end
        a1 = 12'h002;
        #1;
        chk("big_rd2", 32'(q1), 32'h0000);

        // Random traffic against array models
        for (int i = 0; i < 16; i++) begin
            m0[i] = 8'h00;
            m2[i] = 16'h0000;
        end
        m2[3] = 16'h1234;
        left = 0;
        for (int n = 0; n < 300; n++) begin
            rl = ($urandom_range(0, 1) == 1);
            rc = ($urandom_range(0, 19) == 0);
            ra = 4'($urandom_range(0, 15));
            rd = 16'($urandom);
            ld0 = rl; cl0 = rc; a0 = ra; d0 = rd[7:0];
            ld2 = ($urandom_range(0, 1) == 1);
            a2 = 4'($urandom_range(0, 15));
            d2 = 16'($urandom);
            #1;
            chk("rnd_busy", 32'(b0), 32'(left > 0));
            chk("rnd_done", 32'(cd0), 32'(left == 1));
            chk("rnd_out0", 32'(q0), (left > 0) ? 32'd0 : 32'(m0[ra]));
            exp2 = ld2 ? d2 : m2[a2];
            if (ld2) m2[a2] = d2;
            if (left > 0) begin
                left--;
            end else begin
                if (rl) m0[ra] = rd[7:0];
                if (rc) begin
                    left = 16;
                    for (int i = 0; i < 16; i++) m0[i] = 8'h00;
                end
            end
            tick();
            chk("rnd_out2", 32'(q2), 32'(exp2));
        end
        ld0 = 0; cl0 = 0; ld2 = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
